// File: rtl/pbus_tmr_pkg.sv
// Shared constants and lane helpers for the peripheral-bus timer.
package pbus_tmr_pkg;

  localparam int XLEN        = 32;
  localparam int BUS_WIDTH   = 32;
  localparam int BUS_ACC_CNT = 3;
  localparam int ACC_W       = $clog2(BUS_ACC_CNT);

  // Access sizes carried on acc.
  localparam logic [ACC_W-1:0] BUS_ACC_BYTE = ACC_W'(0);
  localparam logic [ACC_W-1:0] BUS_ACC_HALF = ACC_W'(1);
  localparam logic [ACC_W-1:0] BUS_ACC_WORD = ACC_W'(2);

  // Register word indices (byte offset >> 2).
  localparam logic [2:0] TMR_CTRL = 3'd0;
  localparam logic [2:0] TMR_STAT = 3'd1;
  localparam logic [2:0] TMR_CNT  = 3'd2;
  localparam logic [2:0] TMR_CMP  = 3'd3;
  localparam logic [2:0] TMR_PRE  = 3'd4;

  // CTRL bit positions.
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  // Half on an odd byte or word off a word boundary; unknown sizes are treated as bad.
  function automatic logic misaligned(input logic [1:0] lane, input logic [ACC_W-1:0] acc);
    case (acc)
      BUS_ACC_BYTE: misaligned = 1'b0;
      BUS_ACC_HALF: misaligned = lane[0];
      BUS_ACC_WORD: misaligned = |lane;
      default:      misaligned = 1'b1;
    endcase
  endfunction

  // Replace the addressed lane of old_val with the low-aligned write data.
  function automatic logic [BUS_WIDTH-1:0] lane_merge(input logic [BUS_WIDTH-1:0] old_val,
                                                      input logic [BUS_WIDTH-1:0] wdata,
                                                      input logic [1:0]           lane,
                                                      input logic [ACC_W-1:0]     acc);
    logic [BUS_WIDTH-1:0] res;
    res = old_val;
    case (acc)
      BUS_ACC_BYTE: res[{lane, 3'b000} +: 8]     = wdata[7:0];
      BUS_ACC_HALF: res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      BUS_ACC_WORD: res = wdata;
      default:      res = old_val;
    endcase
    return res;
  endfunction

  // Pull the addressed lane down to bit 0, zero-extended.
  function automatic logic [BUS_WIDTH-1:0] lane_extract(input logic [BUS_WIDTH-1:0] val,
                                                        input logic [1:0]           lane,
                                                        input logic [ACC_W-1:0]     acc);
    logic [BUS_WIDTH-1:0] res;
    res = '0;
    case (acc)
      BUS_ACC_BYTE: res[7:0]  = val[{lane, 3'b000} +: 8];
      BUS_ACC_HALF: res[15:0] = val[{lane[1], 4'b0000} +: 16];
      BUS_ACC_WORD: res       = val;
      default:      res       = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pbus_tmr_prescaler.sv
// Prescaler: emits a one-cycle tick every PRE+1 enabled cycles.
module pbus_tmr_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [PRE_W-1:0] pre_i,
  input  logic             pre_wr_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pcnt_q, pcnt_d;

  assign tick_o = en_i && (pcnt_q == pre_i);

  // Next prescaler count: wrap on tick, restart when disabled or PRE is rewritten.
  always_comb begin
    // NOTE: default first so every path assigns pcnt_d and no latch is inferred.
    pcnt_d = pcnt_q + 1'b1;
    if (!en_i || pre_wr_i || tick_o) pcnt_d = '0;
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rstn) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/pbus_tmr.sv
// Peripheral-bus timer: register file, lane merge, counter with compare/auto-reload.
module pbus_tmr
  import pbus_tmr_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req,
  input  logic [XLEN-1:0]      addr,
  input  logic                 w_rb,
  input  logic [ACC_W-1:0]     acc,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic                 resp,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 irq
);

  logic [2:0]           ctrl_q, ctrl_d;
  logic                 match_q, match_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cmp_q, cmp_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic                 resp_q;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0]           lane;
  logic [2:0]           idx;
  logic                 bad, wr;
  logic [BUS_WIDTH-1:0] reg_view, merged, rd_val;
  logic                 tick, wr_cnt, wr_pre;
  logic                 unused_addr;

  assign lane        = addr[1:0];
  assign idx         = addr[4:2];
  assign unused_addr = ^addr[XLEN-1:5];
  assign bad         = misaligned(lane, acc);
  assign wr          = req && w_rb && !bad;
  assign wr_cnt      = wr && (idx == TMR_CNT);
  assign wr_pre      = wr && (idx == TMR_PRE);

  pbus_tmr_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk      (clk),
    .rstn     (rstn),
    .en_i     (ctrl_q[CTRL_EN]),
    .pre_i    (pre_q),
    .pre_wr_i (wr_pre),
    .tick_o   (tick)
  );

  // Full-word view of the addressed register; reserved offsets read as zero.
  always_comb begin
    reg_view = '0;
    case (idx)
      TMR_CTRL: reg_view = BUS_WIDTH'(ctrl_q);
      TMR_STAT: reg_view = BUS_WIDTH'(match_q);
      TMR_CNT:  reg_view = BUS_WIDTH'(cnt_q);
      TMR_CMP:  reg_view = BUS_WIDTH'(cmp_q);
      TMR_PRE:  reg_view = BUS_WIDTH'(pre_q);
      default:  reg_view = '0;
    endcase
  end

  assign merged = lane_merge(reg_view, wdata, lane, acc);
  assign rd_val = bad ? '0 : lane_extract(reg_view, lane, acc);

  // Register-file next state: bus writes, counter advance and MATCH set/clear.
  always_comb begin
    ctrl_d  = ctrl_q;
    match_d = match_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    pre_d   = pre_q;
    rdata_d = rdata_q;

    if (wr && idx == TMR_CTRL) ctrl_d = merged[2:0];
    if (wr && idx == TMR_CMP)  cmp_d  = merged[CNT_W-1:0];
    if (wr_pre)                pre_d  = merged[PRE_W-1:0];
    // Only lane 0 carries the MATCH bit; clear is write-one.
    if (wr && idx == TMR_STAT && lane == 2'd0 && wdata[0]) match_d = 1'b0;

    // A CNT write owns the counter for this cycle; a coinciding tick is lost.
    if (wr_cnt) begin
      cnt_d = merged[CNT_W-1:0];
    end else if (tick) begin
      if (cnt_q == cmp_q) begin
        match_d = 1'b1;
        cnt_d   = ctrl_q[CTRL_AR] ? '0 : cnt_q + 1'b1;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
    end

    if (req && !w_rb) rdata_d = rd_val;
  end

  // Register file and bus response flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      pre_q   <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      pre_q   <= pre_d;
      resp_q  <= req;
      rdata_q <= rdata_d;
    end
  end

  assign resp  = resp_q;
  assign rdata = rdata_q;
  assign irq   = match_q && ctrl_q[CTRL_IE];

endmodule
